// File: rtl/mem_arbiter.sv
// Memory port arbiter: shares one request/response memory port between the
// instruction fetch and data stages. Data access normally wins; a saturating
// starvation counter forces a fetch grant after STARVE_MAX consecutive data
// grants while fetch is waiting. Only one transaction is in flight at a time.
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [XLEN-1:0]     if_addr,
    output logic [XLEN-1:0]     if_rdata,
    output logic                if_done,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [XLEN/8-1:0]   dm_be,
    input  logic [XLEN-1:0]     dm_addr,
    input  logic [XLEN-1:0]     dm_wdata,
    output logic [XLEN-1:0]     dm_rdata,
    output logic                dm_done,

    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,

    output logic                stall_if,
    output logic                stall_dm
);

    localparam int BEW = XLEN / 8;
    localparam int CW  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        WAIT_IF,
        REQ_DM,
        WAIT_DM,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Fields of the granted transaction, held stable while it is presented
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [BEW-1:0]  lat_be;
    logic            lat_we;
    logic            owner_if;

    logic [CW-1:0]   starve_cnt;

    logic if_cand, dm_cand;
    logic grant_if, grant_dm;
    logic cap_if, cap_dm;

    // Arbitration: only evaluated in IDLE; fetch wins only when data is absent or fetch is starved
    always_comb begin
        if_cand  = 1'b0;
        dm_cand  = 1'b0;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            if_cand = if_req & ~if_done;
            dm_cand = dm_req & ~dm_done;
            if (if_cand && (!dm_cand || starve_cnt == STARVE_LIMIT)) begin
                grant_if = 1'b1;
            end else if (dm_cand) begin
                grant_dm = 1'b1;
            end
        end
    end

    // Response capture: a read/ack may arrive together with the grant or later in WAIT
    always_comb begin
        cap_if = ((state == REQ_IF) && mem_gnt && mem_rvalid) ||
                 ((state == WAIT_IF) && mem_rvalid);
        cap_dm = ((state == REQ_DM) && mem_gnt && mem_rvalid) ||
                 ((state == WAIT_DM) && mem_rvalid);
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_nxt = REQ_IF;
                end else if (grant_dm) begin
                    state_nxt = REQ_DM;
                end
            end
            REQ_IF: begin
                if (mem_gnt) begin
                    state_nxt = mem_rvalid ? DONE : WAIT_IF;
                end
            end
            WAIT_IF: begin
                if (mem_rvalid) begin
                    state_nxt = DONE;
                end
            end
            REQ_DM: begin
                if (mem_gnt) begin
                    state_nxt = mem_rvalid ? DONE : WAIT_DM;
                end
            end
            WAIT_DM: begin
                if (mem_rvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winner's request fields at the grant decision; fetch is always a full-word read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_we    <= 1'b0;
            owner_if  <= 1'b0;
        end else if (grant_if) begin
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_be    <= '1;
            lat_we    <= 1'b0;
            owner_if  <= 1'b1;
        end else if (grant_dm) begin
            lat_addr  <= dm_addr;
            lat_wdata <= dm_wdata;
            lat_be    <= dm_be;
            lat_we    <= dm_we;
            owner_if  <= 1'b0;
        end
    end

    // Starvation counter: counts data grants made while fetch is waiting, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Per-requester read data holds the last captured response until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if (cap_if) begin
                if_rdata <= mem_rdata;
            end
            if (cap_dm) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    assign if_done   = (state == DONE) &&  owner_if;
    assign dm_done   = (state == DONE) && !owner_if;

    assign mem_req   = (state == REQ_IF) || (state == REQ_DM);
    assign mem_we    = mem_req & lat_we;
    assign mem_be    = lat_be;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign stall_if  = if_req & ~if_done;
    assign stall_dm  = dm_req & ~dm_done;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter STARVE_MAX, default 4, max consecutive data grants while fetch waits.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  fetch read request, level, held until if_done.
REQ-006 if_addr  input  XLEN  fetch address, stable while if_req.
REQ-007 if_rdata  output  XLEN  fetched instruction, valid when if_done.
REQ-008 if_done  output  1  one-cycle fetch completion pulse.
REQ-009 dm_req, dm_we  input  1 each  data request, write select; held until dm_done.
REQ-010 dm_be  input  XLEN/8  byte enables; dm_addr, dm_wdata  input  XLEN.
REQ-011 dm_rdata  output  XLEN  load data, valid when dm_done; dm_done  output  1  one-cycle pulse.
REQ-012 mem_req, mem_we  output  1 each; mem_be  output  XLEN/8; mem_addr, mem_wdata  output  XLEN  shared memory port.
REQ-013 mem_gnt  input  1  memory accepts presented request this cycle.
REQ-014 mem_rvalid  input  1  response (read data or write ack); mem_rdata  input  XLEN.
REQ-015 stall_if, stall_dm  output  1 each  pipeline stall to fetch / memory stage.

Function
REQ-016 FSM states: IDLE, REQ_IF, WAIT_IF, REQ_DM, WAIT_DM, DONE.
REQ-017 IDLE: dm_req wins over if_req, except if_req wins when starve_cnt == STARVE_MAX.
REQ-018 A requester whose done is high this cycle is ignored by IDLE arbitration.
REQ-019 On grant decision in IDLE: latch addr/we/be/wdata into registers, go REQ_IF or REQ_DM next cycle.
REQ-020 REQ_x: mem_req=1 driving latched fields; hold until mem_gnt; then WAIT_x.
REQ-021 Fetch grants drive mem_we=0, mem_be all ones.
REQ-022 mem_gnt and mem_rvalid in same REQ_x cycle: capture data, go DONE directly.
REQ-023 WAIT_x: mem_req=0; on mem_rvalid capture mem_rdata, go DONE.
REQ-024 DONE: pulse matching x_done=1 for exactly one cycle, x_rdata = captured value; next state IDLE.
REQ-025 x_rdata holds last captured value until the next completion for that requester.
REQ-026 Latency, zero-wait memory (gnt immediate, rvalid next cycle): req rise to done = 4 cycles.
REQ-027 mem_rvalid outside REQ_x/WAIT_x ignored; mem_gnt outside REQ_x ignored.
REQ-028 Requester dropping req after grant does not abort; transaction completes and done pulses.
REQ-029 starve_cnt (saturating at STARVE_MAX): +1 on each data grant while if_req=1; clear on fetch grant or if_req=0.
REQ-030 stall_if = if_req & ~if_done; stall_dm = dm_req & ~dm_done (combinational).
REQ-031 At most one transaction outstanding on the memory port.

Reset
REQ-032 rst_n=0 forces immediately: state IDLE, starve_cnt 0, latched fields 0, mem_req 0, if_done/dm_done 0, if_rdata/dm_rdata 0.
REQ-033 Reset mid-transaction abandons it; no done pulse; late mem_rvalid after release ignored in IDLE.

Verification
REQ-034 if_req, addr 0x100, gnt immediate, rvalid next cycle with rdata 0x00500093 -> mem_req one cycle, if_done pulse 4 cycles after req, if_rdata 0x00500093.
REQ-035 if_req and dm_req rise same cycle, dm_we=1, addr 0x2000, wdata 0xDEADBEEF -> data first (mem_we=1, be 0xF), dm_done, then fetch served, if_done.
REQ-036 dm_req held continuously back-to-back, if_req high -> after 4 data grants fetch granted next; starve_cnt clears.
REQ-037 mem_gnt delayed 3 cycles, rvalid delayed 2 -> mem_req held 4 cycles with stable addr; stall_dm high until dm_done.
REQ-038 rst_n low during WAIT_IF then rvalid after release -> no if_done, mem_req 0, state IDLE.
